// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the divided-clock ratio monitor.
package clk_mon_pkg;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

  // Saturation value of a width-bit period counter.
  function automatic int unsigned cnt_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/clk_ratio_monitor_if.sv
// Bundle of the monitored divided clock and the measurement results.
interface clk_ratio_monitor_if #(
  parameter int CNT_W = 8
);

  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             err;
  logic             timeout;

  modport master (
    output sig_in,
    input  period, high_time, period_valid, locked, err, timeout
  );

  modport slave (
    input  sig_in,
    output period, high_time, period_valid, locked, err, timeout
  );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, plus one history flop
// that yields single-cycle rise/fall strobes in the clk domain.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;
  assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures period and high time of a divided clock in master-clock cycles
// and reports lock, out-of-tolerance periods and loss of toggling.
module clk_ratio_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_RATIO  = 8,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4
) (
  input logic                clk,
  input logic                rst,
  clk_ratio_monitor_if.slave mon
);

  import clk_mon_pkg::*;

  localparam logic [CNT_W-1:0] CntMax    = CNT_W'(cnt_max(CNT_W));
  localparam int               MatchW    = $clog2(LOCK_COUNT + 1);
  localparam logic [MatchW-1:0] MatchFull = MatchW'(LOCK_COUNT);
  localparam logic [CNT_W:0]   ExpExt    = (CNT_W + 1)'(EXP_RATIO);
  localparam logic [CNT_W:0]   TolExt    = (CNT_W + 1)'(TOL);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  highCnt_q, highCnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  highTime_q, highTime_d;
  logic [MatchW-1:0] matchCnt_q, matchCnt_d;
  logic              periodValid_q, periodValid_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;

  logic level;
  logic rise;
  logic fall;

  logic [CNT_W:0] cntExt;
  logic [CNT_W:0] diff;
  logic           inTol;

  sync_edge_det u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (mon.sig_in),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // One extra bit keeps the absolute difference from wrapping.
  assign cntExt = {1'b0, cnt_q};
  assign diff   = (cntExt >= ExpExt) ? (cntExt - ExpExt) : (ExpExt - cntExt);
  assign inTol  = (diff <= TolExt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      highCnt_q     <= '0;
      period_q      <= '0;
      highTime_q    <= '0;
      matchCnt_q    <= '0;
      periodValid_q <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      highCnt_q     <= highCnt_d;
      period_q      <= period_d;
      highTime_q    <= highTime_d;
      matchCnt_q    <= matchCnt_d;
      periodValid_q <= periodValid_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    highCnt_d     = highCnt_q;
    period_d      = period_q;
    highTime_d    = highTime_q;
    matchCnt_d    = matchCnt_q;
    locked_d      = locked_q;
    periodValid_d = 1'b0;
    err_d         = 1'b0;
    timeout_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        highCnt_d = '0;
        if (rise) begin
          cnt_d     = CNT_W'(1);
          highCnt_d = CNT_W'(1);
          state_d   = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d      = cnt_q;
          periodValid_d = 1'b1;
          if (inTol) begin
            if (matchCnt_q != MatchFull) begin
              matchCnt_d = matchCnt_q + MatchW'(1);
            end
            locked_d = (matchCnt_d == MatchFull);
          end else begin
            err_d      = 1'b1;
            locked_d   = 1'b0;
            matchCnt_d = '0;
          end
          cnt_d     = CNT_W'(1);
          highCnt_d = CNT_W'(1);
        end else if (cnt_q == CntMax) begin
          // Divided clock stopped: drop lock and wait for a fresh rise.
          timeout_d  = 1'b1;
          locked_d   = 1'b0;
          matchCnt_d = '0;
          cnt_d      = '0;
          highCnt_d  = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (level) begin
            highCnt_d = highCnt_q + CNT_W'(1);
          end
          if (fall) begin
            highTime_d = highCnt_q;
          end
        end
      end
    endcase
  end

  assign mon.period       = period_q;
  assign mon.high_time    = highTime_q;
  assign mon.period_valid = periodValid_q;
  assign mon.locked       = locked_q;
  assign mon.err          = err_q;
  assign mon.timeout      = timeout_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Self-checking bench for clk_ratio_monitor: scoreboarded period reports
// from two instances (TOL=0 and TOL=1) plus reset, timeout and lock scenarios.
module tb_clk_ratio_monitor;

  typedef struct {
    int period;
    int highTime;
    bit err;
    bit locked;
  } expect_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int nChecks    = 0;
  int nFails     = 0;
  int cyc        = 0;
  int riseCyc    = 0;
  int timeoutCnt = 0;

  expect_t q0[$];
  expect_t q1[$];
  expect_t prevPeriod[2];
  bit      armed[2];
  int      match[2];
  int      tolOf[2] = '{0, 1};
  expect_t mon0E;
  expect_t mon1E;

  clk_ratio_monitor_if #(.CNT_W(8)) bus0 ();
  clk_ratio_monitor_if #(.CNT_W(8)) bus1 ();

  clk_ratio_monitor #(
    .CNT_W(8), .EXP_RATIO(8), .TOL(0), .LOCK_COUNT(4)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .mon (bus0.slave)
  );

  clk_ratio_monitor #(
    .CNT_W(8), .EXP_RATIO(8), .TOL(1), .LOCK_COUNT(4)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .mon (bus1.slave)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for dut0: every period_valid pops one expected measurement.
  always @(negedge clk) begin
    if (rst) begin
      if (bus0.period_valid) begin
        nChecks++;
        if (q0.size() == 0) begin
          nFails++;
          $display("[TB] FAIL dut0 unexpected period_valid: got period=%0d, expected none", bus0.period);
        end else begin
          mon0E = q0.pop_front();
          if (bus0.period !== 8'(mon0E.period)) begin
            nFails++;
            $display("[TB] FAIL dut0 period: got %0d, expected %0d", bus0.period, mon0E.period);
          end
          nChecks++;
          if (bus0.high_time !== 8'(mon0E.highTime)) begin
            nFails++;
            $display("[TB] FAIL dut0 high_time: got %0d, expected %0d", bus0.high_time, mon0E.highTime);
          end
          nChecks++;
          if (bus0.err !== mon0E.err) begin
            nFails++;
            $display("[TB] FAIL dut0 err: got %b, expected %b (period %0d)", bus0.err, mon0E.err, mon0E.period);
          end
          nChecks++;
          if (bus0.locked !== mon0E.locked) begin
            nFails++;
            $display("[TB] FAIL dut0 locked: got %b, expected %b", bus0.locked, mon0E.locked);
          end
        end
      end else if (bus0.err !== 1'b0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL dut0 err outside period_valid: got %b, expected 0", bus0.err);
      end
      if (bus0.timeout === 1'b1) timeoutCnt++;
    end
  end

  // Scoreboard for dut1 (timeouts there are expected between its scenarios).
  always @(negedge clk) begin
    if (rst && bus1.period_valid) begin
      nChecks++;
      if (q1.size() == 0) begin
        nFails++;
        $display("[TB] FAIL dut1 unexpected period_valid: got period=%0d, expected none", bus1.period);
      end else begin
        mon1E = q1.pop_front();
        if (bus1.period !== 8'(mon1E.period)) begin
          nFails++;
          $display("[TB] FAIL dut1 period: got %0d, expected %0d", bus1.period, mon1E.period);
        end
        nChecks++;
        if (bus1.err !== mon1E.err) begin
          nFails++;
          $display("[TB] FAIL dut1 err: got %b, expected %b (period %0d)", bus1.err, mon1E.err, mon1E.period);
        end
        nChecks++;
        if (bus1.locked !== mon1E.locked) begin
          nFails++;
          $display("[TB] FAIL dut1 locked: got %b, expected %b", bus1.locked, mon1E.locked);
        end
      end
    end
  end

  // Drives one divided-clock period (hi cycles high, lo low) starting at a
  // negedge; the period before it completes at this rise, so its expected
  // report is modelled and queued here.
  task automatic applyStimulus(input int which, input int hi, input int lo);
    expect_t e;
    int d;
    if (armed[which]) begin
      e = prevPeriod[which];
      d = e.period - 8;
      if (d < 0) d = -d;
      if (d <= tolOf[which]) begin
        if (match[which] < 4) match[which]++;
        e.err    = 1'b0;
        e.locked = (match[which] == 4);
      end else begin
        match[which] = 0;
        e.err        = 1'b1;
        e.locked     = 1'b0;
      end
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
    end
    prevPeriod[which].period   = hi + lo;
    prevPeriod[which].highTime = hi;
    armed[which] = 1'b1;
    if (which == 0) begin
      bus0.sig_in = 1'b1;
      riseCyc     = cyc;
    end else begin
      bus1.sig_in = 1'b1;
    end
    repeat (hi) @(negedge clk);
    if (which == 0) bus0.sig_in = 1'b0;
    else            bus1.sig_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset();
    #10;
    nChecks++;
    if ({bus0.period, bus0.high_time, bus0.period_valid, bus0.locked, bus0.err, bus0.timeout} !== 20'h0) begin
      nFails++;
      $display("[TB] FAIL reset outputs: got period=%0d high=%0d pv=%b lk=%b err=%b to=%b, expected all 0",
               bus0.period, bus0.high_time, bus0.period_valid, bus0.locked, bus0.err, bus0.timeout);
    end
    #39 rst = 1'b1;
    @(negedge clk);
    nChecks++;
    if ({bus1.period_valid, bus1.locked, bus1.err, bus1.timeout} !== 4'h0) begin
      nFails++;
      $display("[TB] FAIL post-release flags: got pv=%b lk=%b err=%b to=%b, expected 0",
               bus1.period_valid, bus1.locked, bus1.err, bus1.timeout);
    end
  endtask

  task automatic test_tolerance();
    armed[1] = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(1, 4, (i % 2 == 0) ? 3 : 5);
    nChecks++;
    if (bus1.locked !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL tolerance lock: got locked=%b, expected 1", bus1.locked);
    end
    armed[1] = 1'b0;
  endtask

  task automatic test_lock_clk8();
    armed[0] = 1'b0;
    repeat (6) applyStimulus(0, 4, 4);
    nChecks++;
    if (bus0.locked !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL clk8 lock: got locked=%b, expected 1", bus0.locked);
    end
  endtask

  task automatic test_mismatch_clk4();
    repeat (5) applyStimulus(0, 2, 2);
    nChecks++;
    if (bus0.locked !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL clk4 lock: got locked=%b, expected 0", bus0.locked);
    end
  endtask

  task automatic test_err_inject();
    repeat (5) applyStimulus(0, 4, 4);
    applyStimulus(0, 3, 3);
    repeat (5) applyStimulus(0, 4, 4);
    nChecks++;
    if (bus0.locked !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL relock after bad period: got locked=%b, expected 1", bus0.locked);
    end
  endtask

  task automatic test_timeout();
    int seen     = 0;
    int at       = -1;
    bit lockedAt = 1'b1;
    armed[0] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus0.timeout === 1'b1) begin
        seen++;
        if (at < 0) begin
          at       = cyc - riseCyc;
          lockedAt = bus0.locked;
        end
      end
    end
    nChecks++;
    if (seen != 1) begin
      nFails++;
      $display("[TB] FAIL timeout pulse count: got %0d, expected 1", seen);
    end
    nChecks++;
    if (at != 258) begin
      nFails++;
      $display("[TB] FAIL timeout latency: got %0d cycles after sig_in rise, expected 258", at);
    end
    nChecks++;
    if (lockedAt !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL locked at timeout: got %b, expected 0", lockedAt);
    end
    match[0] = 0;
    repeat (6) applyStimulus(0, 4, 4);
    nChecks++;
    if (bus0.locked !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL relock after timeout: got locked=%b, expected 1", bus0.locked);
    end
  endtask

  task automatic test_reset_midperiod();
    applyStimulus(0, 4, 4);
    @(negedge clk);
    nChecks++;
    if (bus0.locked !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL locked before reset: got %b, expected 1", bus0.locked);
    end
    #5 rst = 1'b0;
    #1;
    nChecks++;
    if ({bus0.period, bus0.high_time, bus0.period_valid, bus0.locked, bus0.err, bus0.timeout} !== 20'h0) begin
      nFails++;
      $display("[TB] FAIL async reset outputs: got period=%0d high=%0d pv=%b lk=%b err=%b to=%b, expected all 0",
               bus0.period, bus0.high_time, bus0.period_valid, bus0.locked, bus0.err, bus0.timeout);
    end
    armed[0] = 1'b0;
    armed[1] = 1'b0;
    match[0] = 0;
    match[1] = 0;
    #10 rst = 1'b1;
    @(negedge clk);
    repeat (3) applyStimulus(0, 4, 4);
  endtask

  task automatic test_back_to_back_drain();
    repeat (4) @(negedge clk);
    nChecks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      nFails++;
      $display("[TB] FAIL missing period_valid: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
    end
    nChecks++;
    if (timeoutCnt != 1) begin
      nFails++;
      $display("[TB] FAIL dut0 total timeouts: got %0d, expected 1", timeoutCnt);
    end
  endtask

  initial begin
    bus0.sig_in = 1'b0;
    bus1.sig_in = 1'b0;
    armed[0] = 1'b0;
    armed[1] = 1'b0;
    match[0] = 0;
    match[1] = 0;
    #1 rst = 1'b0;
    test_reset();
    test_tolerance();
    test_lock_clk8();
    test_mismatch_clk4();
    test_err_inject();
    test_timeout();
    test_reset_midperiod();
    test_back_to_back_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", nChecks, nFails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
